// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot sequencer.
package imem_boot_ctrl_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned WORD_SHIFT = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFill,
    StHold,
    StRun
  } boot_state_e;

  function automatic logic [INST_W-1:0] word_to_byte(input logic [INST_W-1:0] word_idx);
    return word_idx << WORD_SHIFT;
  endfunction

endpackage

// File: rtl/imem_addr_mux.sv
// Inst_mem address/write-enable select: loader owns the port while writing,
// otherwise the IFU fetch address passes straight through.
module imem_addr_mux
  import imem_boot_ctrl_pkg::*;
(
  input  logic              ld_wr_en,
  input  logic [INST_W-1:0] ld_addr,
  input  logic [INST_W-1:0] ifu_addr,
  output logic [INST_W-1:0] mem_addr,
  output logic              mem_wr_en
);

  always_comb begin
    mem_wr_en = ld_wr_en;
    mem_addr  = ld_wr_en ? ld_addr : ifu_addr;
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: streams a program image into Inst_mem, optionally zero-fills
// the tail, then releases CPU reset after a short hold.
module imem_boot_ctrl
  import imem_boot_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ZERO_FILL   = 1,
  parameter int unsigned RELEASE_DLY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [INST_W-1:0] ifu_addr,
  output logic [INST_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so the counter can sit at DEPTH without wrapping.
  localparam int unsigned WcntW = $clog2(DEPTH) + 1;

  boot_state_e       state_q, state_d;
  logic [WcntW-1:0]  wcnt_q, wcnt_d;
  logic [3:0]        dly_q, dly_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [INST_W-1:0] wr_addr_q, wr_addr_d;
  logic [INST_W-1:0] wr_data_q, wr_data_d;
  logic              xfer;
  logic              full;

  assign in_ready  = (state_q == StLoad);
  assign cpu_rst_n = (state_q == StRun);
  assign busy      = (state_q == StLoad) || (state_q == StFill) || (state_q == StHold);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_wdata = wr_data_q;

  assign xfer = in_valid && in_ready;
  assign full = (wcnt_q == WcntW'(DEPTH));

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    dly_d     = dly_q;
    err_d     = err_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      StIdle, StRun: begin
        if (load_start) begin
          state_d = StLoad;
          wcnt_d  = '0;
          err_d   = 1'b0;
          dly_d   = '0;
        end
      end

      StLoad: begin
        if (xfer) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = word_to_byte(INST_W'(wcnt_q));
            wr_data_d = in_data;
            wcnt_d    = wcnt_q + WcntW'(1);
          end
          if (in_last) begin
            if (ZERO_FILL != 0 && (INST_W'(wcnt_q) + 32'd1 < DEPTH)) begin
              state_d = StFill;
            end else begin
              state_d = StHold;
            end
          end
        end
      end

      StFill: begin
        wr_en_d   = 1'b1;
        wr_addr_d = word_to_byte(INST_W'(wcnt_q));
        wr_data_d = '0;
        wcnt_d    = wcnt_q + WcntW'(1);
        if (INST_W'(wcnt_q) == DEPTH - 1) begin
          state_d = StHold;
        end
      end

      StHold: begin
        // The final write drains during the first HOLD cycle; count only after it.
        if (!wr_en_q) begin
          if (dly_q == 4'(RELEASE_DLY - 1)) begin
            state_d = StRun;
            dly_d   = '0;
            done_d  = 1'b1;
          end else begin
            dly_d = dly_q + 4'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wcnt_q    <= '0;
      dly_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      dly_q     <= dly_d;
      err_q     <= err_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  imem_addr_mux u_addr_mux (
    .ld_wr_en  (wr_en_q),
    .ld_addr   (wr_addr_q),
    .ifu_addr  (ifu_addr),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en)
  );

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench: dut_a (DEPTH=8, zero fill) and dut_b (DEPTH=4, no fill)
// share the stream inputs; sel picks which one is being exercised.
module tb_imem_boot_ctrl;

  localparam int unsigned DLY = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load_start_a, load_start_b, in_valid, in_last, sel;
  logic [31:0] in_data, ifu_addr;

  logic        rdy_a, we_a, crn_a, busy_a, done_a, err_a;
  logic [31:0] addr_a, wdata_a;
  logic        rdy_b, we_b, crn_b, busy_b, done_b, err_b;
  logic [31:0] addr_b, wdata_b;

  imem_boot_ctrl #(.DEPTH(8), .ZERO_FILL(1), .RELEASE_DLY(DLY)) u_dut_a (
    .clk(clk), .rst(rst), .load_start(load_start_a), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy_a), .ifu_addr(ifu_addr), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .mem_wr_en(we_a), .cpu_rst_n(crn_a), .busy(busy_a), .done(done_a),
    .err(err_a)
  );

  imem_boot_ctrl #(.DEPTH(4), .ZERO_FILL(0), .RELEASE_DLY(DLY)) u_dut_b (
    .clk(clk), .rst(rst), .load_start(load_start_b), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy_b), .ifu_addr(ifu_addr), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_wr_en(we_b), .cpu_rst_n(crn_b), .busy(busy_b), .done(done_b),
    .err(err_b)
  );

  logic        act_rdy, act_we, act_crn, act_busy, act_done, act_err;
  logic [31:0] act_addr, act_wdata;
  assign act_rdy   = sel ? rdy_b   : rdy_a;
  assign act_we    = sel ? we_b    : we_a;
  assign act_crn   = sel ? crn_b   : crn_a;
  assign act_busy  = sel ? busy_b  : busy_a;
  assign act_done  = sel ? done_b  : done_a;
  assign act_err   = sel ? err_b   : err_a;
  assign act_addr  = sel ? addr_b  : addr_a;
  assign act_wdata = sel ? wdata_b : wdata_a;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          m_wcnt, wr_cnt, wr_first, wr_last, hs_cyc;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Every memory write is popped against the expectation pushed at handshake time.
  always @(negedge clk) begin
    if (act_we) begin
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h want no write", act_addr, act_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({act_addr, act_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   act_addr, act_wdata, e[63:32], e[31:0]);
        end
      end
      if (wr_cnt == 0) wr_first = cyc;
      wr_last = cyc;
      wr_cnt++;
    end
  end

  function automatic int depth();
    return sel ? 4 : 8;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    if (sel) load_start_b = 1'b1;
    else     load_start_a = 1'b1;
    m_wcnt = 0;
    wr_cnt = 0;
    step();
    load_start_a = 1'b0;
    load_start_b = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (act_rdy) begin
        if (m_wcnt < depth()) begin
          exp_q.push_back({32'(m_wcnt * 4), d});
          m_wcnt++;
        end
        if (last && !sel) begin
          while (m_wcnt < depth()) begin
            exp_q.push_back({32'(m_wcnt * 4), 32'h0});
            m_wcnt++;
          end
        end
        ok = 1'b1;
      end
      step();
    end
    hs_cyc = cyc;
    in_last = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout got no handshake want in_ready within 20 cycles");
    end
  endtask

  task automatic wait_release(input bit after_write);
    int n_done, rise, exp_rise;
    n_done = 0;
    rise   = -1;
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (act_done) n_done++;
      if (act_crn) begin
        rise = cyc;
        break;
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (act_done) n_done++;
    end
    exp_rise = after_write ? wr_last + int'(DLY) + 1 : hs_cyc + int'(DLY);
    checks++;
    if (rise !== exp_rise) begin
      errors++;
      $display("FAIL release_cycle got %0d want %0d", rise, exp_rise);
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL done_pulses got %0d want 1", n_done);
    end
    checks++;
    if ({act_crn, act_busy} !== 2'b10) begin
      errors++;
      $display("FAIL run_state got crn/busy=%b want 10", {act_crn, act_busy});
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL missing_writes got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({crn_a, rdy_a, we_a, busy_a, done_a, err_a} !== 6'b0 || wdata_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_a got %b/%h want 000000/0",
               {crn_a, rdy_a, we_a, busy_a, done_a, err_a}, wdata_a);
    end
    checks++;
    if ({crn_b, rdy_b, we_b, busy_b, done_b, err_b} !== 6'b0 || wdata_b !== 32'h0) begin
      errors++;
      $display("FAIL reset_b got %b/%h want 000000/0",
               {crn_b, rdy_b, we_b, busy_b, done_b, err_b}, wdata_b);
    end
  endtask

  task automatic test_basic();
    logic [31:0] img[4];
    img = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0020_81B3};
    sel = 1'b1;
    start();
    checks++;
    if ({act_rdy, act_busy, act_crn} !== 3'b110) begin
      errors++;
      $display("FAIL basic_load_state got %b want 110", {act_rdy, act_busy, act_crn});
    end
    for (int i = 0; i < 4; i++) send(img[i], i == 3);
    wait_release(1'b1);
    checks++;
    if (wr_cnt !== 4 || wr_last - wr_first !== 3) begin
      errors++;
      $display("FAIL basic_writes got n=%0d span=%0d want n=4 span=3", wr_cnt, wr_last - wr_first);
    end
    ifu_addr = 32'h0000_1234;
    #1;
    checks++;
    if (act_addr !== 32'h0000_1234) begin
      errors++;
      $display("FAIL ifu_passthru got %h want 00001234", act_addr);
    end
  endtask

  task automatic test_zero_fill();
    sel = 1'b0;
    start();
    for (int i = 0; i < 3; i++) send(32'hA000_0000 + 32'(i), i == 2);
    wait_release(1'b1);
    checks++;
    if (wr_cnt !== 8 || wr_last - wr_first !== 7) begin
      errors++;
      $display("FAIL fill_writes got n=%0d span=%0d want n=8 span=7", wr_cnt, wr_last - wr_first);
    end
  endtask

  task automatic test_bubbles();
    sel = 1'b1;
    start();
    for (int i = 0; i < 4; i++) begin
      send(32'hB000_0000 + 32'(i), i == 3);
      if (i != 3) begin
        in_valid = 1'b0;
        step();
      end
    end
    wait_release(1'b1);
    checks++;
    if (wr_cnt !== 4 || wr_last - wr_first !== 6) begin
      errors++;
      $display("FAIL bubble_writes got n=%0d span=%0d want n=4 span=6", wr_cnt, wr_last - wr_first);
    end
  endtask

  task automatic test_overflow();
    sel = 1'b1;
    start();
    for (int i = 0; i < 6; i++) begin
      send(32'hC000_0000 + 32'(i), i == 5);
      checks++;
      if (act_err !== (i >= 4)) begin
        errors++;
        $display("FAIL ovf_err_word%0d got %b want %b", i + 1, act_err, i >= 4);
      end
    end
    wait_release(1'b0);
    checks++;
    if (act_err !== 1'b1 || wr_cnt !== 4) begin
      errors++;
      $display("FAIL ovf_run got err=%b n=%0d want err=1 n=4", act_err, wr_cnt);
    end
  endtask

  task automatic test_reload();
    sel = 1'b1;
    start();
    checks++;
    if ({act_crn, act_err, act_busy, act_rdy} !== 4'b0011) begin
      errors++;
      $display("FAIL reload_entry got crn/err/busy/rdy=%b want 0011",
               {act_crn, act_err, act_busy, act_rdy});
    end
    send(32'hD000_0001, 1'b0);
    send(32'hD000_0002, 1'b1);
    wait_release(1'b1);
    checks++;
    if (wr_cnt !== 2 || act_err !== 1'b0) begin
      errors++;
      $display("FAIL reload_writes got n=%0d err=%b want n=2 err=0", wr_cnt, act_err);
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    start();
    send(32'hE000_0000, 1'b0);
    send(32'hE000_0001, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if ({act_crn, act_rdy, act_we, act_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid got crn/rdy/we/busy=%b want 0000",
               {act_crn, act_rdy, act_we, act_busy});
    end
    load_start_a = 1'b1;
    step();
    load_start_a = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if ({act_crn, act_rdy, act_busy} !== 3'b000) begin
      errors++;
      $display("FAIL rst_wins got crn/rdy/busy=%b want 000", {act_crn, act_rdy, act_busy});
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rst_mid_writes got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    load_start_a = 1'b0;
    load_start_b = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 32'h0;
    ifu_addr = 32'h0000_0040;
    sel = 1'b0;
    wr_cnt = 0;
    wr_first = 0;
    wr_last = 0;
    m_wcnt = 0;
    hs_cyc = 0;
    test_reset();
    test_basic();
    test_zero_fill();
    test_bubbles();
    test_overflow();
    test_reload();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Boot sequencer for the instruction memory. Holds the CPU in reset while it streams a program image into Inst_mem word by word, optionally zero-fills the unused tail, then releases CPU reset.
- Owns the Inst_mem address/write-enable mux: the loader drives memory while loading; the IFU fetch address passes through otherwise.
- Sits between the host/loader stream source, Inst_mem, and the ifu/if_id reset input.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words; power of 2.
- ZERO_FILL, 1, if 1, write 32'h0 to every word after the last loaded word up to DEPTH-1.
- RELEASE_DLY, 2, cycles cpu_rst_n stays low after the final memory write (range 1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse; begins a new load session.
- in_valid  in  1  stream word valid.
- in_data  in  32  stream instruction word.
- in_last  in  1  marks the final word of the image; qualified by in_valid.
- in_ready  out  1  stream ready.
- ifu_addr  in  32  IFU fetch byte address.
- mem_addr  out  32  Inst_mem byte address.
- mem_wdata  out  32  Inst_mem write data.
- mem_wr_en  out  1  Inst_mem write enable.
- cpu_rst_n  out  1  active-low reset to ifu/if_id/core.
- busy  out  1  high in any state other than RUN and IDLE.
- done  out  1  one-cycle pulse on entry to RUN.
- err  out  1  sticky overflow flag; cleared by rst or load_start.

Behaviour:
- FSM states:
  - IDLE (reset state): cpu_rst_n=0, in_ready=0.
  - LOAD: in_ready=1.
  - FILL
  - HOLD
  - RUN: cpu_rst_n=1.
- Reset values: state=IDLE, in_ready=0, mem_wr_en=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0, word counter wcnt=0, delay counter=0.
- IDLE→LOAD on load_start. Also RUN→LOAD on load_start: cpu_rst_n drops the same edge. load_start in LOAD/FILL/HOLD is ignored.
- Entry to LOAD clears wcnt and err.
- LOAD handshake: transfer when in_valid&&in_ready.
  - Next cycle: mem_wr_en=1, mem_wdata=in_data, write address = wcnt*4 (byte address, low 2 bits 0).
  - wcnt increments. Write latency is 1 cycle; throughput 1 word/cycle.
- Transfer with in_last:
  - ZERO_FILL=1 and wcnt+1<DEPTH: go to FILL.
  - Otherwise: go to HOLD.
- Overflow: a transfer when wcnt==DEPTH is accepted, not written, and sets err. The FSM stays in LOAD until in_last, which goes straight to HOLD. wcnt saturates at DEPTH; it never wraps.
- FILL: in_ready=0. One write per cycle of 32'h0 at wcnt*4 until wcnt==DEPTH-1 is written, then HOLD.
- HOLD: in_ready=0, mem_wr_en=0. Counts RELEASE_DLY cycles, then RUN.
- RUN: cpu_rst_n=1 and done=1 for exactly the first RUN cycle.
- Address mux (combinational): mem_addr = registered loader address when mem_wr_en=1, else ifu_addr. mem_wr_en is never high in RUN or IDLE.
- busy=1 in LOAD, FILL, HOLD.
- First write after the last loaded word:
  - The FILL write at address N*4 follows the final LOAD write at (N-1)*4 in the next cycle.
  - No gap and no duplicate write.
- rst mid-session: every register returns to its reset value next edge and the CPU stays in reset. A partially written memory is not erased.
- rst and load_start together: rst wins.

Decomposition:
- Shared package/defines (define.v): state encodings (IDLE, LOAD, FILL, HOLD, RUN), INST_W=32, word-to-byte shift constant 2.
- One natural sub-module: imem_addr_mux, the combinational loader/IFU address and write-enable select. Counters and FSM stay in the top.

Test Plan:
- Basic load, ZERO_FILL=0: 4 words 0x00000013, 0x00100093, 0x00200113, 0x002081B3 (last), back-to-back valid → writes at 0x0/0x4/0x8/0xC on consecutive cycles, then HOLD 2 cycles, cpu_rst_n rises, done pulses once, mem_addr follows ifu_addr.
- Zero fill, DEPTH=8: 3 words loaded → zeros written at 0xC..0x1C in 5 consecutive cycles, with the first immediately after the 0x8 write, then release.
- Backpressure/bubbles: in_valid toggling 1,0,1,0 → writes occur only on handshake cycles; addresses contiguous.
- Overflow, DEPTH=4: 6 words → 4 writes, err=1 after the 5th, words 5–6 dropped, release still occurs, err stays set in RUN.
- Reload: load_start in RUN → cpu_rst_n=0 the next cycle, err/wcnt cleared, new image written from 0x0.
- Reset mid-LOAD: rst asserted after 2 words → next cycle IDLE, cpu_rst_n=0, in_ready=0, mem_wr_en=0; rst with simultaneous load_start stays IDLE.
